// File: rtl/text_scroll_engine.sv
// Glyph-column scroller: buffers up to WORD_COUNT 7-bit character codes and
// streams them to a column-driven display, one column per step pulse.
// Codes with bit6 set select a font glyph; otherwise bits[5:0] are emitted
// directly as a single raw column.
module text_scroll_engine #(
  parameter  int WORD_COUNT = 16,
  parameter  int GLYPH_COLS = 8,
  localparam int PTR_W      = $clog2(WORD_COUNT),
  localparam int CNT_W      = $clog2(WORD_COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [6:0]       i_wr_data,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_oneshot,
  input  logic             i_step,
  output logic [7:0]       o_col_out,
  output logic             o_col_valid,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state,     w_state_n;
  logic [CNT_W-1:0] r_count,     w_count_n;
  logic [PTR_W-1:0] r_wr_ptr,    w_wr_ptr_n;
  logic [PTR_W-1:0] r_rd_ptr,    w_rd_ptr_n;
  logic [2:0]       r_col,       w_col_n;
  logic [7:0]       r_col_out,   w_col_out_n;
  logic             r_col_valid, w_col_valid_n;
  logic             r_oneshot,   w_oneshot_n;
  logic [6:0]       r_buf [WORD_COUNT];

  logic             w_full;
  logic             w_wr_ok;
  logic [CNT_W-1:0] w_cnt_post;
  logic [6:0]       w_char;
  logic             w_last;
  logic             w_adv;

  // Font: glyph columns 1..6 packed msb-first; column 0 and column 7 are blank.
  function automatic logic [41:0] glyph_bits(input logic [5:0] code);
    case (code)
      6'h10: glyph_bits = {7'h3E, 7'h61, 7'h51, 7'h49, 7'h45, 7'h3E}; // 0
      6'h11: glyph_bits = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00, 7'h00}; // 1
      6'h12: glyph_bits = {7'h62, 7'h51, 7'h49, 7'h49, 7'h46, 7'h00}; // 2
      6'h13: glyph_bits = {7'h22, 7'h41, 7'h49, 7'h49, 7'h36, 7'h00}; // 3
      6'h14: glyph_bits = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10, 7'h00}; // 4
      6'h15: glyph_bits = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39, 7'h00}; // 5
      6'h16: glyph_bits = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30, 7'h00}; // 6
      6'h17: glyph_bits = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03, 7'h00}; // 7
      6'h18: glyph_bits = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36, 7'h00}; // 8
      6'h19: glyph_bits = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E, 7'h00}; // 9
      6'h21: glyph_bits = {7'h7C, 7'h12, 7'h11, 7'h11, 7'h12, 7'h7C}; // A
      6'h22: glyph_bits = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36, 7'h00}; // B
      6'h23: glyph_bits = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22, 7'h00}; // C
      6'h24: glyph_bits = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C, 7'h00}; // D
      6'h25: glyph_bits = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41, 7'h00}; // E
      6'h26: glyph_bits = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01, 7'h00}; // F
      6'h27: glyph_bits = {7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A, 7'h00}; // G
      6'h28: glyph_bits = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F, 7'h00}; // H
      6'h29: glyph_bits = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00, 7'h00}; // I
      6'h2A: glyph_bits = {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01, 7'h00}; // J
      6'h2B: glyph_bits = {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41, 7'h00}; // K
      6'h2C: glyph_bits = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00}; // L
      6'h2D: glyph_bits = {7'h7F, 7'h02, 7'h0C, 7'h02, 7'h7F, 7'h00}; // M
      6'h2E: glyph_bits = {7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F, 7'h00}; // N
      6'h2F: glyph_bits = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E, 7'h00}; // O
      6'h30: glyph_bits = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06, 7'h00}; // P
      6'h31: glyph_bits = {7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E, 7'h00}; // Q
      6'h32: glyph_bits = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46, 7'h00}; // R
      6'h33: glyph_bits = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31, 7'h00}; // S
      6'h34: glyph_bits = {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01, 7'h00}; // T
      6'h35: glyph_bits = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h00}; // U
      6'h36: glyph_bits = {7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F, 7'h00}; // V
      6'h37: glyph_bits = {7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F, 7'h00}; // W
      6'h38: glyph_bits = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63, 7'h00}; // X
      6'h39: glyph_bits = {7'h07, 7'h08, 7'h70, 7'h08, 7'h07, 7'h00}; // Y
      6'h3A: glyph_bits = {7'h61, 7'h51, 7'h49, 7'h45, 7'h43, 7'h00}; // Z
      default: glyph_bits = '0;
    endcase
  endfunction

  // Font lookup for one column; column 0 and column 7 always read blank.
  function automatic logic [6:0] rom_col(input logic [5:0] code, input logic [2:0] col);
    logic [41:0] g;
    g = glyph_bits(code);
    case (col)
      3'd1:    rom_col = g[41:35];
      3'd2:    rom_col = g[34:28];
      3'd3:    rom_col = g[27:21];
      3'd4:    rom_col = g[20:14];
      3'd5:    rom_col = g[13:7];
      3'd6:    rom_col = g[6:0];
      default: rom_col = 7'h00;
    endcase
  endfunction

  assign w_full     = (r_count == CNT_W'(WORD_COUNT));
  assign w_wr_ok    = !i_clear && (r_state == S_IDLE) && i_wr_en && !w_full;
  assign w_cnt_post = w_wr_ok ? (r_count + 1'b1) : r_count;
  assign w_char     = r_buf[r_rd_ptr];
  assign w_last     = (CNT_W'(r_rd_ptr) == (r_count - 1'b1));

  // Next-state and next-output decode: clear first, then run-drop, then state actions.
  always_comb begin
    w_state_n     = r_state;
    w_count_n     = r_count;
    w_wr_ptr_n    = r_wr_ptr;
    w_rd_ptr_n    = r_rd_ptr;
    w_col_n       = r_col;
    w_col_out_n   = r_col_out;
    w_col_valid_n = 1'b0;
    w_oneshot_n   = r_oneshot;
    w_adv         = 1'b0;
    if (i_clear) begin
      w_state_n   = S_IDLE;
      w_count_n   = '0;
      w_wr_ptr_n  = '0;
      w_rd_ptr_n  = '0;
      w_col_n     = '0;
      w_col_out_n = 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_col_out_n = 8'h00;
          if (w_wr_ok) begin
            w_wr_ptr_n = r_wr_ptr + 1'b1;
            w_count_n  = w_cnt_post;
          end
          // A same-cycle write counts toward the start condition.
          if (i_run && (w_cnt_post != '0)) begin
            w_state_n   = S_RUN;
            w_oneshot_n = i_oneshot;
            w_rd_ptr_n  = '0;
            w_col_n     = '0;
          end
        end
        S_RUN: begin
          if (!i_run) begin
            w_state_n   = S_IDLE;
            w_rd_ptr_n  = '0;
            w_col_n     = '0;
            w_col_out_n = 8'h00;
          end else if (i_step) begin
            w_col_valid_n = 1'b1;
            if (!w_char[6]) begin
              w_col_out_n = {1'b0, w_char[5:0], 1'b0};
              w_adv       = 1'b1;
            end else begin
              w_col_out_n = {1'b0, rom_col(w_char[5:0], r_col)};
              if (r_col == 3'(GLYPH_COLS - 1)) begin
                w_col_n = '0;
                w_adv   = 1'b1;
              end else begin
                w_col_n = r_col + 1'b1;
              end
            end
            if (w_adv) begin
              if (w_last) begin
                w_rd_ptr_n = '0;
                if (r_oneshot) w_state_n = S_DONE;
              end else begin
                w_rd_ptr_n = r_rd_ptr + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          w_col_out_n = 8'h00;
          if (!i_run) begin
            w_state_n  = S_IDLE;
            w_rd_ptr_n = '0;
            w_col_n    = '0;
          end
        end
        default: begin
          w_state_n   = S_IDLE;
          w_col_out_n = 8'h00;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_col       <= '0;
      r_col_out   <= 8'h00;
      r_col_valid <= 1'b0;
      r_oneshot   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_col       <= w_col_n;
      r_col_out   <= w_col_out_n;
      r_col_valid <= w_col_valid_n;
      r_oneshot   <= w_oneshot_n;
    end
  end

  // Character buffer; contents need no reset since count gates what is played.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_buf[r_wr_ptr] <= i_wr_data;
  end

  assign o_col_out   = r_col_out;
  assign o_col_valid = r_col_valid;
  assign o_done      = (r_state == S_DONE);
  assign o_count     = r_count;
  assign o_full      = w_full;

endmodule
